cpu_run_ctrl: RTL and testbench

Run/step control stage that sits directly downstream of the CPU clock divider. It samples the divided `cpu_clk` in the `system_clk` domain and turns each rising edge into a one-cycle `cpu_en` strobe. The strobe is gated by a run switch, a debounced single-step button and a halt request from the CPU core. The core's state registers use `cpu_en` as their enable, so the board can free-run, single-step or freeze the CPU without gating any clock.

---
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step gate for the CPU: turns divided-clock rising edges into one-cycle cpu_en strobes
// qualified by run switch, debounced step button and core halt. cpu_en lands two edges after cpu_clk is first sampled high.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_LEN = 16
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       cpu_clk,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic       halt,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic [7:0] step_count
);

  localparam int CW = $clog2(DEBOUNCE_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t cur_state, nxt_state;

  logic [1:0]    clk_sy, run_sy, btn_sy, halt_sy;
  logic          clk_s, run_s, btn_s, halt_s;
  logic          clk_d;
  logic          tick;
  logic          btn_q, btn_q_d;
  logic [CW-1:0] db_cnt;
  logic          step_evt;
  logic          en_nxt;

  // All four inputs are asynchronous to system_clk, cpu_clk included.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      clk_sy  <= 2'b00;
      run_sy  <= 2'b00;
      btn_sy  <= 2'b00;
      halt_sy <= 2'b00;
      clk_d   <= 1'b0;
    end else begin
      clk_sy  <= {clk_sy[0], cpu_clk};
      run_sy  <= {run_sy[0], run_sw};
      btn_sy  <= {btn_sy[0], step_btn};
      halt_sy <= {halt_sy[0], halt};
      clk_d   <= clk_s;
    end
  end

  assign clk_s  = clk_sy[1];
  assign run_s  = run_sy[1];
  assign btn_s  = btn_sy[1];
  assign halt_s = halt_sy[1];
  assign tick   = clk_s & ~clk_d;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      btn_q    <= 1'b0;
      btn_q_d  <= 1'b0;
      db_cnt   <= '0;
      step_evt <= 1'b0;
    end else begin
      btn_q_d  <= btn_q;
      step_evt <= btn_q & ~btn_q_d;
      if (btn_s == btn_q) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        btn_q  <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      cur_state  <= IDLE;
      cpu_en     <= 1'b0;
      step_count <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      cpu_en    <= en_nxt;
      if (en_nxt) begin
        step_count <= step_count + 8'd1;
      end
    end
  end

  // Halt wins in every state; step events outside IDLE fall on the floor.
  always_comb begin
    nxt_state = cur_state;
    en_nxt    = 1'b0;
    case (cur_state)
      IDLE: begin
        if (halt_s)        nxt_state = HALTED;
        else if (run_s)    nxt_state = RUN;
        else if (step_evt) nxt_state = STEP;
      end
      RUN: begin
        if (halt_s) begin
          nxt_state = HALTED;
        end else begin
          en_nxt = tick;
          if (!run_s) nxt_state = IDLE;
        end
      end
      STEP: begin
        if (halt_s) begin
          nxt_state = HALTED;
        end else if (tick) begin
          en_nxt    = 1'b1;
          nxt_state = IDLE;
        end
      end
      HALTED: begin
        if (!halt_s && !run_s) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign state = cur_state;

  a_no_back_to_back: assert property (@(posedge system_clk) disable iff (!reset) cpu_en |=> !cpu_en);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scenario bench for cpu_run_ctrl: randomized cpu_clk phases and button bounce, expectations from event-level rules.
module tb_cpu_run_ctrl;

  localparam int D = 16;

  logic       system_clk;
  logic       reset;
  logic       cpu_clk;
  logic       run_sw;
  logic       step_btn;
  logic       halt;
  logic       cpu_en;
  logic [1:0] state;
  logic [7:0] step_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses[$];
  int exp_count = 0;

  cpu_run_ctrl #(.DEBOUNCE_LEN(D)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .cpu_clk    (cpu_clk),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .state      (state),
    .step_count (step_count)
  );

  initial begin
    system_clk = 1'b0;
    forever #5 system_clk = ~system_clk;
  end

  initial forever @(posedge system_clk) cyc++;

  // Records the edge index of every cycle in which cpu_en is seen high.
  initial forever begin
    @(negedge system_clk);
    if (reset === 1'b1 && cpu_en === 1'b1) pulses.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step_edges(input int n);
    repeat (n) begin
      @(posedge system_clk);
      #1;
    end
  endtask

  // One cpu_clk period; rise is the edge index just before cpu_clk goes high.
  task automatic cpu_cycle(input int hi, input int lo, output int rise);
    cpu_clk = 1'b1;
    rise = cyc;
    step_edges(hi);
    cpu_clk = 1'b0;
    step_edges(lo);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= lim; i++) begin
      if (state === s) begin
        ok = 1'b1;
        break;
      end
      step_edges(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k % 17 == 0) cpu_clk = ~cpu_clk;
      step_edges(1);
      checks++;
      if (cpu_en !== 1'b0 || state !== 2'd0 || step_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: cpu_en=%b state=%0d step_count=%0d expected 0/0/0", k, cpu_en, state, step_count);
      end
    end
    reset = 1'b1;
    pulses.delete();
    for (int k = 5; k < 45; k++) begin
      if (k % 17 == 0) cpu_clk = ~cpu_clk;
      step_edges(1);
    end
    cpu_clk = 1'b0;
    step_edges(6);
    checks++;
    if (state !== 2'd0 || pulses.size() != 0 || step_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d pulses=%0d step_count=%0d expected 0/0/0", state, pulses.size(), step_count);
    end
  endtask

  task automatic test_free_run;
    int exp_q[$];
    int rise;
    bit ok;
    run_sw = 1'b1;
    step_edges(2);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL run_early: state=%0d expected 0 two edges after run_sw", state);
    end
    step_edges(1);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL run_latency: state=%0d expected 1 three edges after run_sw", state);
    end
    pulses.delete();
    for (int i = 0; i < 10; i++) begin
      cpu_cycle($urandom_range(2, 20), $urandom_range(2, 20), rise);
      exp_q.push_back(rise + 3);
    end
    exp_count += 10;
    step_edges(4);
    checks++;
    if (pulses.size() != exp_q.size()) begin
      errors++;
      $display("FAIL run_pulse_count: got %0d pulses, expected %0d", pulses.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (pulses[i] != exp_q[i]) begin
          errors++;
          $display("FAIL run_pulse_time[%0d]: pulse at edge %0d, expected edge %0d", i, pulses[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (step_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL run_step_count: got %0d, expected %0d", step_count, exp_count);
    end
    run_sw = 1'b0;
    step_edges(3);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL run_stop: state=%0d expected 0 within 3 edges", state);
    end
    wait_state(2'd0, 5, ok);
  endtask

  task automatic test_step;
    int rise;
    pulses.delete();
    for (int i = 0; i < 5; i++) begin
      step_btn = 1'b1;
      step_edges($urandom_range(1, 6));
      step_btn = 1'b0;
      step_edges($urandom_range(1, 6));
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL step_bounce: state=%0d expected 0 after short bounces", state);
    end
    step_btn = 1'b1;
    step_edges(40);
    checks++;
    if (state !== 2'd2 || pulses.size() != 0) begin
      errors++;
      $display("FAIL step_enter: state=%0d pulses=%0d expected 2/0", state, pulses.size());
    end
    step_btn = 1'b0;
    step_edges(40);
    step_btn = 1'b1;
    step_edges(40);
    step_btn = 1'b0;
    step_edges(40);
    checks++;
    if (state !== 2'd2 || pulses.size() != 0) begin
      errors++;
      $display("FAIL step_second_press: state=%0d pulses=%0d expected 2/0", state, pulses.size());
    end
    cpu_cycle($urandom_range(2, 20), $urandom_range(4, 20), rise);
    exp_count += 1;
    checks++;
    if (pulses.size() != 1 || (pulses.size() == 1 && pulses[0] != rise + 3)) begin
      errors++;
      $display("FAIL step_pulse: pulses=%0d first_at=%0d expected 1 at edge %0d", pulses.size(),
               (pulses.size() > 0) ? pulses[0] : -1, rise + 3);
    end
    checks++;
    if (state !== 2'd0 || step_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL step_return: state=%0d step_count=%0d expected 0/%0d", state, step_count, exp_count);
    end
    cpu_cycle($urandom_range(2, 20), $urandom_range(4, 20), rise);
    checks++;
    if (pulses.size() != 1) begin
      errors++;
      $display("FAIL step_dropped_evt: pulses=%0d expected 1 (second press must not queue)", pulses.size());
    end
  endtask

  task automatic test_halt;
    int rise;
    bit ok;
    run_sw = 1'b1;
    wait_state(2'd1, 6, ok);
    step_edges(4);
    pulses.delete();
    halt = 1'b1;
    step_edges(1);
    cpu_cycle(10, 10, rise);
    checks++;
    if (pulses.size() != 0 || state !== 2'd3) begin
      errors++;
      $display("FAIL halt_enter: pulses=%0d state=%0d expected 0/3", pulses.size(), state);
    end
    halt = 1'b0;
    step_edges(8);
    cpu_cycle($urandom_range(2, 20), $urandom_range(4, 20), rise);
    checks++;
    if (state !== 2'd3 || pulses.size() != 0) begin
      errors++;
      $display("FAIL halt_hold_run: state=%0d pulses=%0d expected 3/0", state, pulses.size());
    end
    run_sw = 1'b0;
    step_edges(4);
    checks++;
    if (state !== 2'd0 || step_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL halt_release: state=%0d step_count=%0d expected 0/%0d", state, step_count, exp_count);
    end
  endtask

  task automatic test_wrap;
    int rise;
    int exp_q[$];
    int bad;
    bit ok;
    reset = 1'b0;
    step_edges(2);
    reset = 1'b1;
    exp_count = 0;
    run_sw = 1'b1;
    wait_state(2'd1, 6, ok);
    pulses.delete();
    for (int i = 0; i < 257; i++) begin
      cpu_cycle($urandom_range(2, 4), $urandom_range(2, 4), rise);
      exp_q.push_back(rise + 3);
      exp_count = (exp_count + 1) % 256;
      if (i == 255) begin
        checks++;
        if (step_count !== 8'(exp_count)) begin
          errors++;
          $display("FAIL wrap_256: step_count=%0d expected %0d", step_count, exp_count);
        end
      end
    end
    step_edges(3);
    checks++;
    if (step_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257: step_count=%0d expected 1", step_count);
    end
    bad = 0;
    if (pulses.size() == exp_q.size()) begin
      foreach (exp_q[i]) if (pulses[i] != exp_q[i]) bad++;
    end
    checks++;
    if (pulses.size() != exp_q.size() || bad != 0) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d pulses with %0d misplaced, expected %0d on time", pulses.size(), bad, exp_q.size());
    end
    run_sw = 1'b0;
    wait_state(2'd0, 6, ok);
  endtask

  task automatic test_reset_mid_pulse;
    int rise;
    bit seen;
    bit ok;
    bit early;
    run_sw = 1'b1;
    wait_state(2'd1, 6, ok);
    cpu_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge system_clk);
      if (cpu_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_pulse_seen: cpu_en never rose within 8 edges, expected a pulse");
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cpu_en !== 1'b0 || state !== 2'd0 || step_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: cpu_en=%b state=%0d step_count=%0d expected 0/0/0", cpu_en, state, step_count);
    end
    exp_count = 0;
    run_sw = 1'b0;
    cpu_clk = 1'b0;
    step_btn = 1'b1;
    step_edges(3);
    reset = 1'b1;
    early = 1'b0;
    for (int i = 0; i < D; i++) begin
      step_edges(1);
      if (state !== 2'd0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL held_btn_early: left IDLE within %0d edges of reset release, expected to stay 0", D);
    end
    wait_state(2'd2, 8, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL held_btn_step: state=%0d expected 2 after debounce of held button", state);
    end
    step_btn = 1'b0;
    pulses.delete();
    cpu_cycle($urandom_range(2, 20), $urandom_range(4, 20), rise);
    exp_count += 1;
    checks++;
    if (pulses.size() != 1 || step_count !== 8'(exp_count) || state !== 2'd0) begin
      errors++;
      $display("FAIL held_btn_pulse: pulses=%0d step_count=%0d state=%0d expected 1/%0d/0",
               pulses.size(), step_count, state, exp_count);
    end
  endtask

  initial begin
    reset    = 1'b0;
    cpu_clk  = 1'b0;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    halt     = 1'b0;
    test_reset();
    test_free_run();
    test_step();
    test_halt();
    test_wrap();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
